// File: rtl/sd_cmd_arbiter.sv
// SD CMD-line arbiter: round-robin grant between the init engine (0) and the
// data engine (1), CRC7 command framing, serial transmit, response capture and
// checking, and Ncc idle gap before the next command.
module sd_cmd_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 40000,
    parameter int unsigned NCC         = 16
) (
    input  logic         SD_clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [5:0]   req0_index,
    input  logic [31:0]  req0_arg,
    input  logic [1:0]   req0_rtype,
    input  logic         req1_valid,
    input  logic [5:0]   req1_index,
    input  logic [31:0]  req1_arg,
    input  logic [1:0]   req1_rtype,
    output logic         req0_ack,
    output logic         req1_ack,
    output logic         SD_cmd_en,
    output logic         SD_cmd,
    input  logic         SD_cmd_resp,
    output logic         busy,
    output logic         resp_valid,
    output logic         resp_id,
    output logic [1:0]   resp_status,
    output logic [135:0] resp_data
);

    // One shared counter serves TX bit count, response wait, RX bit count and gap.
    localparam int unsigned MAX_A = (TIMEOUT_CYC > NCC) ? TIMEOUT_CYC : NCC;
    localparam int unsigned MAX_C = (MAX_A > 136) ? MAX_A : 136;
    localparam int unsigned CNT_W = $clog2(MAX_C + 1);

    localparam logic [1:0] RT_NONE  = 2'd0;
    localparam logic [1:0] RT_SHORT = 2'd1;
    localparam logic [1:0] RT_R3    = 2'd2;
    localparam logic [1:0] RT_LONG  = 2'd3;

    localparam logic [1:0] ST_OK     = 2'd0;
    localparam logic [1:0] ST_TMO    = 2'd1;
    localparam logic [1:0] ST_CRCERR = 2'd2;
    localparam logic [1:0] ST_FMTERR = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_WAIT_RESP,
        S_RX,
        S_GAP
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last_grant;
    logic               r_owner;
    logic [5:0]         r_index;
    logic [1:0]         r_rtype;
    logic [39:0]        r_frame;
    logic [6:0]         r_crc;
    logic [134:0]       r_rx;
    logic               r_cmd_en;
    logic               r_cmd;
    logic               r_resp_valid;
    logic               r_resp_id;
    logic [1:0]         r_resp_status;
    logic [135:0]       r_resp_data;

    logic               w_any;
    logic               w_pick;
    logic               w_accept;
    logic [5:0]         w_sel_index;
    logic [31:0]        w_sel_arg;
    logic [1:0]         w_sel_rtype;
    logic [39:0]        w_frame40;
    logic [135:0]       w_rx_full;
    logic               w_rx_last;
    logic [1:0]         w_rx_status;

    // Serial CRC7, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ ({7{fb}} & 7'h09);
    endfunction

    // Arbitration: on a tie the requester not granted last wins.
    always_comb begin
        w_any       = req0_valid | req1_valid;
        w_pick      = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
        w_accept    = ~rst && (r_state == S_IDLE) && w_any;
        w_sel_index = w_pick ? req1_index : req0_index;
        w_sel_arg   = w_pick ? req1_arg   : req0_arg;
        w_sel_rtype = w_pick ? req1_rtype : req0_rtype;
        w_frame40   = {2'b01, w_sel_index, w_sel_arg};
    end

    // Response capture view including the bit currently on the line, and its checks.
    always_comb begin
        w_rx_full = {r_rx, SD_cmd_resp};
        w_rx_last = (r_rtype == RT_LONG) ? (r_cnt == CNT_W'(135)) : (r_cnt == CNT_W'(47));
        if (!w_rx_full[0]) begin
            w_rx_status = ST_FMTERR;
        end else if ((r_rtype == RT_SHORT) && (w_rx_full[45:40] != r_index)) begin
            w_rx_status = ST_FMTERR;
        end else if ((r_rtype == RT_R3) && (w_rx_full[45:40] != 6'h3f)) begin
            w_rx_status = ST_FMTERR;
        end else if ((r_rtype == RT_LONG) && (w_rx_full[133:128] != 6'h3f)) begin
            w_rx_status = ST_FMTERR;
        end else if ((r_rtype == RT_SHORT) && (r_crc != w_rx_full[7:1])) begin
            w_rx_status = ST_CRCERR;
        end else begin
            w_rx_status = ST_OK;
        end
    end

    // Main controller: arbitration, framing, transmit, response wait/capture, gap.
    always_ff @(posedge SD_clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_last_grant  <= 1'b1;
            r_owner       <= 1'b0;
            r_index       <= '0;
            r_rtype       <= '0;
            r_frame       <= '0;
            r_crc         <= '0;
            r_rx          <= '0;
            r_cmd_en      <= 1'b0;
            r_cmd         <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_resp_id     <= 1'b0;
            r_resp_status <= ST_OK;
            r_resp_data   <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner      <= w_pick;
                        r_last_grant <= w_pick;
                        r_index      <= w_sel_index;
                        r_rtype      <= w_sel_rtype;
                        // Start bit goes out now; the remaining 39 header bits queue up.
                        r_cmd        <= w_frame40[39];
                        r_cmd_en     <= 1'b1;
                        r_frame      <= {w_frame40[38:0], 1'b0};
                        r_crc        <= crc7_step(7'd0, w_frame40[39]);
                        r_cnt        <= CNT_W'(1);
                        r_state      <= S_TX;
                    end
                end

                S_TX: begin
                    // r_cnt is the index of the frame bit being launched this edge.
                    if (r_cnt < CNT_W'(40)) begin
                        r_cmd   <= r_frame[39];
                        r_crc   <= crc7_step(r_crc, r_frame[39]);
                        r_frame <= {r_frame[38:0], 1'b0};
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end else if (r_cnt < CNT_W'(47)) begin
                        r_cmd <= r_crc[6];
                        r_crc <= {r_crc[5:0], 1'b0};
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else if (r_cnt == CNT_W'(47)) begin
                        r_cmd <= 1'b1;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_cmd_en <= 1'b0;
                        r_cmd    <= 1'b1;
                        r_cnt    <= '0;
                        if (r_rtype == RT_NONE) begin
                            r_resp_valid  <= 1'b1;
                            r_resp_id     <= r_owner;
                            r_resp_status <= ST_OK;
                            r_resp_data   <= '0;
                            r_state       <= S_GAP;
                        end else begin
                            r_state <= S_WAIT_RESP;
                        end
                    end
                end

                S_WAIT_RESP: begin
                    // First two samples belong to the bus turnaround.
                    if ((r_cnt >= CNT_W'(2)) && !SD_cmd_resp) begin
                        r_rx    <= '0;
                        r_crc   <= crc7_step(7'd0, 1'b0);
                        r_cnt   <= CNT_W'(1);
                        r_state <= S_RX;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        r_resp_valid  <= 1'b1;
                        r_resp_id     <= r_owner;
                        r_resp_status <= ST_TMO;
                        r_resp_data   <= '0;
                        r_cnt         <= '0;
                        r_state       <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_RX: begin
                    r_rx <= w_rx_full[134:0];
                    // CRC runs over the first 40 received bits (resp[47:8] of a short reply).
                    if (r_cnt < CNT_W'(40)) begin
                        r_crc <= crc7_step(r_crc, SD_cmd_resp);
                    end
                    if (w_rx_last) begin
                        r_resp_valid  <= 1'b1;
                        r_resp_id     <= r_owner;
                        r_resp_status <= w_rx_status;
                        r_resp_data   <= (r_rtype == RT_LONG) ? w_rx_full
                                                              : {88'd0, w_rx_full[47:0]};
                        r_cnt         <= '0;
                        r_state       <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_GAP: begin
                    // Gap covers the resp_valid cycle plus NCC idle cycles.
                    if (r_cnt == CNT_W'(NCC)) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req0_ack    = w_accept & ~w_pick;
    assign req1_ack    = w_accept & w_pick;
    assign busy        = ~rst & ((r_state != S_IDLE) | w_accept);
    assign SD_cmd_en   = r_cmd_en;
    assign SD_cmd      = r_cmd;
    assign resp_valid  = r_resp_valid;
    assign resp_id     = r_resp_id;
    assign resp_status = r_resp_status;
    assign resp_data   = r_resp_data;

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Bench for sd_cmd_arbiter: directed and randomized commands, a card model that
// replies on the CMD line, and a reference model for frames, status and timing.
module tb_sd_cmd_arbiter;

    localparam int TO  = 40000;
    localparam int NCC = 16;

    logic         SD_clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [5:0]   req0_index = '0, req1_index = '0;
    logic [31:0]  req0_arg = '0, req1_arg = '0;
    logic [1:0]   req0_rtype = '0, req1_rtype = '0;
    logic         req0_ack, req1_ack;
    logic         SD_cmd_en, SD_cmd;
    logic         SD_cmd_resp = 1'b1;
    logic         busy, resp_valid, resp_id;
    logic [1:0]   resp_status;
    logic [135:0] resp_data;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rr_last = 1;
    logic [47:0] last_frame;

    sd_cmd_arbiter #(.TIMEOUT_CYC(TO), .NCC(NCC)) dut (
        .SD_clk      (SD_clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_index  (req0_index),
        .req0_arg    (req0_arg),
        .req0_rtype  (req0_rtype),
        .req1_valid  (req1_valid),
        .req1_index  (req1_index),
        .req1_arg    (req1_arg),
        .req1_rtype  (req1_rtype),
        .req0_ack    (req0_ack),
        .req1_ack    (req1_ack),
        .SD_cmd_en   (SD_cmd_en),
        .SD_cmd      (SD_cmd),
        .SD_cmd_resp (SD_cmd_resp),
        .busy        (busy),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_status (resp_status),
        .resp_data   (resp_data)
    );

    always #5 SD_clk = ~SD_clk;
    always @(posedge SD_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CRC7 as the remainder of m(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc7_div(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r = r ^ (47'h89 << (i - 7));
        end
        return r[6:0];
    endfunction

    function automatic logic [1:0] ref_status(input logic [1:0] rt, input logic [5:0] idx,
                                              input logic [135:0] r);
        if (!r[0]) return 2'd3;
        if (rt == 2'd1 && r[45:40] != idx) return 2'd3;
        if (rt == 2'd2 && r[45:40] != 6'h3f) return 2'd3;
        if (rt == 2'd3 && r[133:128] != 6'h3f) return 2'd3;
        if (rt == 2'd1 && crc7_div(r[47:8]) != r[7:1]) return 2'd2;
        return 2'd0;
    endfunction

    task automatic set_req(input int rq, input logic v, input logic [5:0] idx,
                           input logic [31:0] arg, input logic [1:0] rt);
        if (rq == 0) begin
            req0_valid = v; req0_index = idx; req0_arg = arg; req0_rtype = rt;
        end else begin
            req1_valid = v; req1_index = idx; req1_arg = arg; req1_rtype = rt;
        end
    endtask

    // mode: 0 good reply, 1 CRC bit flipped, 2 bad index field, 3 end bit 0,
    // 4 no reply, 5 reset mid-RX.
    task automatic do_cmd(input int rq, input logic [5:0] idx, input logic [31:0] arg,
                          input logic [1:0] rt, input int mode, input int dly,
                          input logic [135:0] payload);
        logic        got_ack;
        logic        early;
        logic        seen;
        logic [47:0] frm, exp_frm;
        logic [135:0] rsp;
        logic [5:0]  fidx;
        logic [6:0]  crc;
        int          en_cnt, w, s, len;

        @(negedge SD_clk);
        set_req(rq, 1'b1, idx, arg, rt);
        got_ack = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if ((rq == 0) ? req0_ack : req1_ack) begin
                got_ack = 1'b1;
                break;
            end
            @(negedge SD_clk);
        end
        chk("ack_seen", got_ack, 1'b1);
        if (!got_ack) begin
            set_req(rq, 1'b0, idx, arg, rt);
            return;
        end
        chk("ack_other_low", (rq == 0) ? req1_ack : req0_ack, 1'b0);
        chk("busy_at_ack", busy, 1'b1);
        rr_last = rq;

        exp_frm = {2'b01, idx, arg, crc7_div({2'b01, idx, arg}), 1'b1};
        frm = '0;
        en_cnt = 0;
        for (int k = 0; k < 48; k++) begin
            @(negedge SD_clk);
            if (k == 0) set_req(rq, 1'b0, idx, arg, rt);
            frm = {frm[46:0], SD_cmd};
            en_cnt += int'(SD_cmd_en);
        end
        last_frame = frm;
        chk("tx_frame", frm, exp_frm);
        chk("tx_en_cycles", en_cnt, 48);
        @(negedge SD_clk);
        chk("en_after_tx", SD_cmd_en, 1'b0);
        chk("cmd_idle_high", SD_cmd, 1'b1);

        if (rt == 2'd0) begin
            chk("rt0_resp_valid", resp_valid, 1'b1);
            chk("rt0_resp_id", resp_id, rq[0]);
            chk("rt0_status", resp_status, 2'd0);
            chk("rt0_data", resp_data, 136'd0);
            return;
        end

        w = cyc;
        if (mode == 4) begin
            early = 1'b0;
            while (cyc < w + TO - 1) begin
                @(negedge SD_clk);
                early |= resp_valid;
            end
            chk("no_early_timeout", early, 1'b0);
            @(negedge SD_clk);
            chk("timeout_rv", resp_valid, 1'b1);
            chk("timeout_cycle", cyc - w, TO);
            chk("timeout_status", resp_status, 2'd1);
            chk("timeout_id", resp_id, rq[0]);
            return;
        end

        if (rt == 2'd3) begin
            len = 136;
            rsp = payload;
            rsp[135:134] = 2'b00;
            rsp[133:128] = (mode == 2) ? 6'h15 : 6'h3f;
            rsp[0] = (mode == 3) ? 1'b0 : 1'b1;
        end else begin
            len = 48;
            fidx = (rt == 2'd2) ? 6'h3f : idx;
            if (mode == 2) fidx = (fidx == 6'd9) ? 6'd10 : 6'd9;
            crc = (rt == 2'd2) ? 7'h7f : crc7_div({2'b00, fidx, payload[31:0]});
            if (mode == 1) crc = crc ^ 7'h08;
            rsp = {88'd0, 2'b00, fidx, payload[31:0], crc, (mode == 3) ? 1'b0 : 1'b1};
        end

        // Low glitch during turnaround must be ignored.
        early = 1'b0;
        SD_cmd_resp = 1'b0;
        @(negedge SD_clk);
        early |= resp_valid;
        @(negedge SD_clk);
        early |= resp_valid;
        for (int d = 0; d < dly; d++) begin
            SD_cmd_resp = 1'b1;
            @(negedge SD_clk);
            early |= resp_valid;
        end
        s = cyc;
        for (int b = 0; b < len; b++) begin
            SD_cmd_resp = rsp[len - 1 - b];
            early |= resp_valid;
            if (mode == 5 && b == 60) begin
                rst = 1'b1;
                @(negedge SD_clk);
                rst = 1'b0;
                SD_cmd_resp = 1'b1;
                rr_last = 1;
                chk("rst_en_low", SD_cmd_en, 1'b0);
                chk("rst_idle", busy, 1'b0);
                chk("rst_no_rv", resp_valid, 1'b0);
                chk("rst_data_clear", resp_data, 136'd0);
                seen = 1'b0;
                for (int i = 0; i < 200; i++) begin
                    @(negedge SD_clk);
                    seen |= resp_valid;
                end
                chk("rst_no_rv_later", seen, 1'b0);
                return;
            end
            if (b < len - 1) @(negedge SD_clk);
        end
        chk("rx_no_early_rv", early, 1'b0);
        @(negedge SD_clk);
        SD_cmd_resp = 1'b1;
        chk("rx_resp_valid", resp_valid, 1'b1);
        chk("rx_latency", cyc - s, len);
        chk("rx_resp_id", resp_id, rq[0]);
        chk("rx_status", resp_status, ref_status(rt, idx, rsp));
        chk("rx_data", resp_data, rsp);
    endtask

    initial begin
        int          rq, mode, dly, which, exp_w, last_rv;
        logic        got;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [1:0]  rt;
        logic [135:0] pl;

        // Reset with a request pending: no ack may escape.
        set_req(0, 1'b1, 6'd5, 32'h1234, 2'd0);
        repeat (3) @(negedge SD_clk);
        chk("rst_ack0", req0_ack, 1'b0);
        chk("rst_ack1", req1_ack, 1'b0);
        chk("rst_cmd_en", SD_cmd_en, 1'b0);
        chk("rst_cmd", SD_cmd, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_id", resp_id, 1'b0);
        chk("rst_resp_status", resp_status, 2'd0);
        chk("rst_resp_data", resp_data, 136'd0);
        set_req(0, 1'b0, 6'd0, 32'd0, 2'd0);
        rst = 1'b0;

        do_cmd(0, 6'd0, 32'd0, 2'd0, 0, 0, 136'd0);
        chk("cmd0_stream", last_frame, 48'h40_0000_0000_95);
        do_cmd(0, 6'd8, 32'h1AA, 2'd1, 0, 3, 136'h1AA);
        chk("cmd8_stream", last_frame, 48'h48_0000_01AA_87);
        do_cmd(0, 6'd8, 32'h1AA, 2'd1, 1, 3, 136'h1AA);
        do_cmd(0, 6'd8, 32'h1AA, 2'd1, 2, 3, 136'h1AA);
        do_cmd(0, 6'd8, 32'h1AA, 2'd1, 4, 0, 136'd0);

        for (int it = 0; it < 10; it++) begin
            rq   = int'($urandom_range(0, 1));
            idx  = 6'($urandom);
            arg  = $urandom;
            rt   = 2'($urandom_range(0, 2));
            mode = int'($urandom_range(0, 3));
            dly  = int'($urandom_range(0, 6));
            pl   = {8'd0, $urandom, $urandom, $urandom, $urandom};
            do_cmd(rq, idx, arg, rt, mode, dly, pl);
        end

        pl = {8'd0, $urandom, $urandom, $urandom, $urandom};
        do_cmd(1, 6'd2, 32'd0, 2'd3, 0, 1, pl);
        pl = {8'd0, $urandom, $urandom, $urandom, $urandom};
        do_cmd(0, 6'd2, 32'd0, 2'd3, 2, 0, pl);
        pl = {8'd0, $urandom, $urandom, $urandom, $urandom};
        do_cmd(1, 6'd2, 32'd0, 2'd3, 5, 0, pl);

        // Both requesters held valid: grants must alternate, each after the gap.
        @(negedge SD_clk);
        rst = 1'b1;
        @(negedge SD_clk);
        rst = 1'b0;
        rr_last = 1;
        set_req(0, 1'b1, 6'd0, 32'd0, 2'd0);
        set_req(1, 1'b1, 6'd55, $urandom, 2'd0);
        last_rv = 0;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            for (int i = 0; i < 200; i++) begin
                #1;
                if (req0_ack | req1_ack) begin
                    got = 1'b1;
                    break;
                end
                @(negedge SD_clk);
            end
            chk("rr_ack_seen", got, 1'b1);
            if (!got) break;
            which = int'(req1_ack);
            exp_w = (rr_last == 0) ? 1 : 0;
            chk("rr_order", which, exp_w);
            chk("rr_single_ack", req0_ack & req1_ack, 1'b0);
            if (g > 0) chk("rr_ncc_gap", (cyc - last_rv) >= NCC + 1, 1'b1);
            rr_last = which;
            got = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge SD_clk);
                if (resp_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("rr_resp_seen", got, 1'b1);
            chk("rr_resp_id", resp_id, which[0]);
            last_rv = cyc;
        end
        set_req(0, 1'b0, 6'd0, 32'd0, 2'd0);
        set_req(1, 1'b0, 6'd0, 32'd0, 2'd0);
        repeat (4) @(negedge SD_clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
